// File: rtl/hififo_tpc_wr_tlp.sv
// hififo_tpc_wr_tlp: turns one block-write request into a single 64-bit
// PCIe Memory Write (MWr64) TLP. The TLP is two header beats followed by
// sixteen payload qwords taken from a first-word-fall-through FIFO.
// Each request moves one 128-byte block, which is 32 DWs.
module hififo_tpc_wr_tlp (
    input  logic        clock,
    input  logic        pci_reset_n,
    // block write requests from the controller
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [63:0] wr_addr,
    input  logic [15:0] requester_id,
    // payload source (first-word-fall-through)
    input  logic [63:0] fifo_data,
    input  logic        fifo_valid,
    output logic        fifo_ready,
    // TLP stream towards the link; the lower DW goes first
    output logic [63:0] tlp_data,
    output logic        tlp_valid,
    output logic        tlp_last,
    input  logic        tlp_ready,
    // completion reporting
    output logic        wr_done,
    output logic [31:0] packets_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR0 = 2'd1,
        HDR1 = 2'd2,
        DATA = 2'd3
    } state_t;

    // 128-byte block = 32 DWs, carried as 16 payload qwords
    localparam logic [9:0] LEN_DW         = 10'd32;
    localparam logic [3:0] LAST_DATA_BEAT = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  beat_q, beat_d;
    logic [63:0] addr_q, addr_d;
    logic        wr_done_q, wr_done_d;
    logic [31:0] pkts_q, pkts_d;

    // High beat of the first header: {DW1, DW0}.
    // DW0 is the fixed MWr64 command word: fmt=011 (4DW header with data),
    // type=00000, TC/attr/TD/EP all zero, length = 32 DWs.
    // DW1 carries requester id, tag 0 and full byte enables.
    function automatic logic [63:0] hdr0_beat(input logic [15:0] rid);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {3'b011, 5'b00000, 1'b0, 3'b000, 4'b0000,
               1'b0, 1'b0, 2'b00, 2'b00, LEN_DW};
        dw1 = {rid, 8'h00, 4'hF, 4'hF};
        return {dw1, dw0};
    endfunction

    // Second header beat: {DW3, DW2} = {address low DW, address high DW}.
    // The latched address already has its seven low bits cleared.
    function automatic logic [63:0] hdr1_beat(input logic [63:0] addr);
        return {addr[31:0], addr[63:32]};
    endfunction

    // A stream beat moves only when the sink takes it; in DATA the beat also
    // needs a qword from the FIFO.
    logic hdr_xfer;
    logic data_xfer;
    logic last_xfer;

    assign hdr_xfer  = tlp_ready;
    assign data_xfer = fifo_valid && tlp_ready;
    assign last_xfer = data_xfer && (beat_q == LAST_DATA_BEAT);

    // Next-state logic: request acceptance, header sequencing, payload beat
    // counting and packet completion.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        wr_done_d = 1'b0;
        pkts_d    = pkts_q;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    // block aligned: the seven low address bits are dropped
                    addr_d  = wr_addr & ~64'h7F;
                    beat_d  = 4'd0;
                    state_d = HDR0;
                end
            end
            HDR0: begin
                if (hdr_xfer) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (hdr_xfer) begin
                    beat_d  = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (data_xfer) begin
                    beat_d = beat_q + 4'd1;
                end
                if (last_xfer) begin
                    state_d   = IDLE;
                    wr_done_d = 1'b1;
                    pkts_d    = pkts_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 4'd0;
            end
        endcase
    end

    // Output decode: headers come from the latched address, payload passes
    // straight from the FIFO so a stalled beat is held by the FIFO itself.
    always_comb begin
        wr_ready   = 1'b0;
        fifo_ready = 1'b0;
        tlp_valid  = 1'b0;
        tlp_last   = 1'b0;
        tlp_data   = 64'd0;
        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
            end
            HDR0: begin
                tlp_valid = 1'b1;
                tlp_data  = hdr0_beat(requester_id);
            end
            HDR1: begin
                tlp_valid = 1'b1;
                tlp_data  = hdr1_beat(addr_q);
            end
            DATA: begin
                tlp_valid  = fifo_valid;
                fifo_ready = tlp_ready;
                tlp_data   = fifo_data;
                tlp_last   = (beat_q == LAST_DATA_BEAT);
            end
            default: begin
                wr_ready = 1'b0;
            end
        endcase
    end

    // State, counters and latched address, cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (!pci_reset_n) begin
            state_q   <= IDLE;
            beat_q    <= 4'd0;
            addr_q    <= 64'd0;
            wr_done_q <= 1'b0;
            pkts_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            wr_done_q <= wr_done_d;
            pkts_q    <= pkts_d;
        end
    end

    assign wr_done      = wr_done_q;
    assign packets_sent = pkts_q;

endmodule

// File: tb/tb_hififo_tpc_wr_tlp.sv
// Bench for hififo_tpc_wr_tlp: a FIFO and sink model drive the DUT, a
// reference model predicts each TLP when a request is accepted, and a
// monitor compares every transferred beat against that prediction.
module tb_hififo_tpc_wr_tlp;

    logic        clock = 1'b0;
    logic        pci_reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_addr;
    logic [15:0] requester_id;
    logic [63:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [63:0] tlp_data;
    logic        tlp_valid;
    logic        tlp_last;
    logic        tlp_ready;
    logic        wr_done;
    logic [31:0] packets_sent;

    always #5 clock = ~clock;

    hififo_tpc_wr_tlp dut (
        .clock        (clock),
        .pci_reset_n  (pci_reset_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .requester_id (requester_id),
        .fifo_data    (fifo_data),
        .fifo_valid   (fifo_valid),
        .fifo_ready   (fifo_ready),
        .tlp_data     (tlp_data),
        .tlp_valid    (tlp_valid),
        .tlp_last     (tlp_last),
        .tlp_ready    (tlp_ready),
        .wr_done      (wr_done),
        .packets_sent (packets_sent)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // payload store behind the FIFO model
    logic [63:0] fifo_mem [0:1023];
    int          fifo_idx = 0;

    // reference model state
    beat_t       exp_q[$];
    logic [63:0] req_q[$];
    logic [63:0] got_q[$];
    int          remaining = 0;   // beats still owed for the current TLP
    int          pkt_cnt   = 0;
    int          pay_cnt   = 0;
    int          pay_idx   = 0;   // next FIFO word a new TLP will carry
    int          acc_cyc   = -1;
    int          acc_n     = 0;
    int          exp_lat   = -1;
    bit          chk_spacing = 0;
    bit          done_due  = 0;
    bit          pop_flag  = 0;
    bit          acc_flag  = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    // stimulus knobs
    bit          rdy_rand   = 0;
    bit          fifo_rand  = 0;
    bit          fifo_hold  = 0;
    bit          hdr1_hold_en = 0;
    bit          held_this  = 0;
    int          hold_cnt   = 0;
    logic [15:0] rid_drv    = 16'h0100;

    beat_t       mon_e;
    logic [63:0] mon_a;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks the DUT state each cycle and, for the edge to come,
    // scores transfers and records acceptances into the model.
    always @(negedge clock) begin
        cyc++;
        pop_flag = fifo_valid && fifo_ready;
        acc_flag = 0;
        if (pci_reset_n) begin
            chk("wr_done", {63'd0, wr_done}, {63'd0, done_due});
            done_due = 0;
            chk("packets_sent", {32'd0, packets_sent}, 64'(pkt_cnt));
            chk("wr_ready", {63'd0, wr_ready}, {63'd0, remaining == 0});
            if (prev_stall) begin
                chk("stall_valid", {63'd0, tlp_valid}, 64'd1);
                chk("stall_data", tlp_data, prev_data);
                chk("stall_last", {63'd0, tlp_last}, {63'd0, prev_last});
            end
            if (remaining == 0)
                chk("idle_valid", {63'd0, tlp_valid}, 64'd0);
            else if (remaining > 16)
                chk("hdr_valid", {63'd0, tlp_valid}, 64'd1);
            else
                chk("data_valid", {63'd0, tlp_valid}, {63'd0, fifo_valid});
            if (remaining == 0 || remaining > 16)
                chk("fifo_ready_off", {63'd0, fifo_ready}, 64'd0);
            else
                chk("fifo_ready_data", {63'd0, fifo_ready}, {63'd0, tlp_ready});
            prev_stall = tlp_valid && !tlp_ready;
            prev_data  = tlp_data;
            prev_last  = tlp_last;

            if (tlp_valid && tlp_ready) begin
                got_q.push_back(tlp_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got %h expected no beat", tlp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", tlp_data, mon_e.d);
                    chk("beat_last", {63'd0, tlp_last}, {63'd0, mon_e.l});
                end
                if (remaining <= 16) pay_cnt++;
                if (remaining > 0) remaining--;
                if (remaining == 0) begin
                    done_due = 1;
                    pkt_cnt++;
                    if (exp_lat >= 0) chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
                end
            end

            if (wr_valid && wr_ready) begin
                acc_flag = 1;
                acc_n++;
                mon_a = wr_addr;
                if (chk_spacing && acc_cyc >= 0) chk("spacing", 64'(cyc - acc_cyc), 64'd19);
                acc_cyc = cyc;
                exp_q.push_back('{d: {requester_id, 16'h00FF, 32'h6000_0020}, l: 1'b0});
                exp_q.push_back('{d: {mon_a[31:7], 7'd0, mon_a[63:32]}, l: 1'b0});
                for (int k = 0; k < 16; k++)
                    exp_q.push_back('{d: fifo_mem[pay_idx + k], l: (k == 15)});
                pay_idx  += 16;
                remaining = 18;
                pay_cnt   = 0;
                held_this = 0;
            end
        end else begin
            prev_stall = 0;
        end
    end

    // Driver: request source, FWFT FIFO and stream sink, updated just after
    // each rising edge.
    initial begin
        wr_valid     = 1'b0;
        wr_addr      = 64'd0;
        requester_id = rid_drv;
        fifo_valid   = 1'b0;
        fifo_data    = 64'd0;
        tlp_ready    = 1'b0;
        forever begin
            bit keep;
            @(posedge clock);
            #1;
            if (pop_flag) fifo_idx++;
            if (acc_flag && req_q.size() > 0) void'(req_q.pop_front());
            wr_valid     = (req_q.size() > 0);
            wr_addr      = wr_valid ? req_q[0] : {$urandom, $urandom};
            requester_id = rid_drv;
            keep = fifo_valid && !pop_flag;
            if (fifo_idx >= 1024)   fifo_valid = 1'b0;
            else if (keep)          fifo_valid = 1'b1;
            else if (fifo_hold)     fifo_valid = 1'b0;
            else                    fifo_valid = fifo_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            fifo_data = (fifo_valid && fifo_idx < 1024) ? fifo_mem[fifo_idx] : {$urandom, $urandom};
            if (hdr1_hold_en && remaining == 17 && !held_this) begin
                hold_cnt  = 10;
                held_this = 1;
            end
            if (hold_cnt > 0) begin
                tlp_ready = 1'b0;
                hold_cnt--;
            end else begin
                tlp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Called at a rising edge; holds reset for n edges and checks the state
    // seen just after release.
    task automatic do_reset(input int n);
        #2;
        pci_reset_n = 1'b0;
        exp_q.delete();
        req_q.delete();
        remaining  = 0;
        pkt_cnt    = 0;
        done_due   = 0;
        prev_stall = 0;
        hold_cnt   = 0;
        acc_cyc    = -1;
        repeat (n) @(posedge clock);
        #2;
        pci_reset_n = 1'b1;
        pay_idx = fifo_idx;
        #1;
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_tlp_valid", {63'd0, tlp_valid}, 64'd0);
        chk("rst_tlp_last", {63'd0, tlp_last}, 64'd0);
        chk("rst_fifo_ready", {63'd0, fifo_ready}, 64'd0);
        chk("rst_wr_done", {63'd0, wr_done}, 64'd0);
        chk("rst_packets", {32'd0, packets_sent}, 64'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req_q.size() > 0 || remaining > 0 || done_due) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d cycles expected under %0d", n, budget);
        end
    endtask

    task automatic wait_pay(input int target, input int budget);
        int n = 0;
        while (!(remaining > 0 && pay_cnt >= target) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL pay_wait: got %0d payload beats expected %0d", pay_cnt, target);
        end
    endtask

    task automatic chk_got(input string name, input int idx, input logic [63:0] exp);
        if (got_q.size() > idx) begin
            chk(name, got_q[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d beats expected beat %0d", name, got_q.size(), idx);
        end
    endtask

    initial begin
        pci_reset_n = 1'b0;
        for (int i = 0; i < 1024; i++) fifo_mem[i] = {$urandom, $urandom};
        @(posedge clock);
        do_reset(3);

        // directed reference packet at full throughput
        @(posedge clock);
        got_q.delete();
        exp_lat = 18;
        rid_drv = 16'h0100;
        req_q.push_back(64'h0000_0001_2345_6780);
        wait_idle(200);
        chk_got("ref_beat0", 0, 64'h0100_00FF_6000_0020);
        chk_got("ref_beat1", 1, 64'h2345_6780_0000_0001);
        chk("ref_beats", 64'(got_q.size()), 64'd18);
        chk("ref_packets", {32'd0, packets_sent}, 64'd1);

        // low address bits must not reach DW3
        got_q.delete();
        rid_drv = 16'hA5C3;
        req_q.push_back(64'hFEDC_BA98_7654_32FF);
        wait_idle(200);
        chk_got("low_bits_beat1", 1, 64'h7654_3280_FEDC_BA98);

        // five empty FIFO cycles after payload beat 3
        got_q.delete();
        exp_lat = 23;
        pay_cnt = 0;
        req_q.push_back({$urandom, $urandom});
        wait_pay(3, 100);
        fifo_hold = 1;
        repeat (5) @(posedge clock);
        fifo_hold = 0;
        wait_idle(200);
        chk("gap_beats", 64'(got_q.size()), 64'd18);

        // random sink stalls with a long hold on HDR1
        exp_lat = -1;
        rdy_rand = 1;
        hdr1_hold_en = 1;
        for (int i = 0; i < 6; i++) begin
            rid_drv = 16'($urandom);
            req_q.push_back({$urandom, $urandom});
            wait_idle(2000);
        end
        hdr1_hold_en = 0;

        // random FIFO gaps as well, requests queued while busy
        fifo_rand = 1;
        for (int i = 0; i < 3; i++) begin
            rid_drv = 16'($urandom);
            req_q.push_back({$urandom, $urandom});
            req_q.push_back({$urandom, $urandom});
            wait_idle(4000);
        end
        chk("rand_packets", {32'd0, packets_sent}, 64'd15);

        // reset in the middle of the payload
        rdy_rand = 0;
        fifo_rand = 0;
        pay_cnt = 0;
        req_q.push_back({$urandom, $urandom});
        wait_pay(8, 100);
        do_reset(1);
        got_q.delete();
        exp_lat = 18;
        req_q.push_back({$urandom, $urandom});
        wait_idle(200);
        chk("post_rst_beats", 64'(got_q.size()), 64'd18);
        chk("post_rst_packets", {32'd0, packets_sent}, 64'd1);

        // four back-to-back requests with wr_valid held high
        @(posedge clock);
        do_reset(2);
        acc_n = 0;
        chk_spacing = 1;
        for (int i = 0; i < 4; i++) req_q.push_back({$urandom, $urandom});
        wait_idle(500);
        chk_spacing = 0;
        chk("b2b_accepts", 64'(acc_n), 64'd4);
        chk("b2b_packets", {32'd0, packets_sent}, 64'd4);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
